// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (800x600@72), scan FSM state type and sync helpers
// used by the text-mode scan sequencer.
package vga_pkg;

  localparam int COORD_W = 11;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 56;
  localparam int H_SYNC_DEF    = 120;
  localparam int H_BACK_DEF    = 64;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 37;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BACK_DEF    = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  // Maps an "asserted" flag onto the pin level for a given sync polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Parameterised DEPTH x WIDTH shift register with a synchronous reset value.
// DEPTH of 0 degenerates to a straight wire.
module sig_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_text_scanner.sv
// VGA scan sequencer: generates the renderer coordinates, delays sync/blank to
// match the renderer pipeline, and starts/stops only on frame boundaries.
module vga_text_scanner
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = 1'b1,
  parameter int PIPE_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         PIXEL_IN,
  output logic [COORD_W-1:0] PIXEL_H,
  output logic [COORD_W-1:0] PIXEL_V,
  output logic [2:0]         vga_rgb,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start,
  output logic [7:0]         frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  scan_state_t        state;
  scan_state_t        state_nxt;
  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               running;
  logic               line_end;
  logic               frame_end;
  logic               active0;
  logic               hs0;
  logic               vs0;
  logic [2:0]         dly_out;

  assign running   = (state != IDLE);
  assign line_end  = (h == H_LAST);
  assign frame_end = line_end && (v == V_LAST);

  // DRAIN lets the current frame finish so the monitor never sees a torn frame.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)             state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (running) begin
        h <= line_end ? '0 : h + 1'b1;
        if (line_end) v <= (v == V_LAST) ? '0 : v + 1'b1;
        if (frame_end) frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign PIXEL_H     = h;
  assign PIXEL_V     = v;
  assign frame_start = (state == RUN) && (h == '0) && (v == '0);

  // Counters sit at (0,0) in IDLE, so stage-0 flags must be gated by running.
  assign active0 = running && (h < H_VIS) && (v < V_VIS);
  assign hs0     = running && (h >= HS_FIRST) && (h <= HS_LAST);
  assign vs0     = running && (v >= VS_FIRST) && (v <= VS_LAST);

  sig_delay #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (3),
    .RST_VAL (3'b000)
  ) u_sig_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({active0, hs0, vs0}),
    .dout (dly_out)
  );

  // Output register is the final delay stage, lining up with PIXEL_IN.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb <= '0;
      vga_hs  <= ~SYNC_POL;
      vga_vs  <= ~SYNC_POL;
    end else begin
      vga_rgb <= dly_out[2] ? PIXEL_IN : 3'b000;
      vga_hs  <= sync_level(dly_out[1], SYNC_POL);
      vga_vs  <= sync_level(dly_out[0], SYNC_POL);
    end
  end

endmodule

// File: tb/tb_vga_text_scanner.sv
// Bench for vga_text_scanner on a tiny 14x7 raster with a two-register stub
// renderer; a frame-position model predicts coordinates, sync and colour.
module tb_vga_text_scanner;

  localparam int HV = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 1, VB = 1;
  localparam int LAT = 2;
  localparam int HT = 14, VT = 7, FT = 98;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [2:0]  pixel_in;
  logic [10:0] pixel_h;
  logic [10:0] pixel_v;
  logic [2:0]  vga_rgb;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  int         m_state = ST_IDLE;
  int         m_pos   = 0;
  logic [7:0] m_fcnt  = '0;
  logic [4:0] hist [3];
  logic [4:0] exp_out = '0;

  logic [2:0] rend_q1, rend_q2;

  always #10 clk = ~clk;

  vga_text_scanner #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
    .SYNC_POL  (1'b1), .PIPE_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .PIXEL_IN    (pixel_in),
    .PIXEL_H     (pixel_h),
    .PIXEL_V     (pixel_v),
    .vga_rgb     (vga_rgb),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  // Coordinate-dependent colour so a misaligned pipeline shows up; bit 2 keeps it non-black.
  function automatic logic [2:0] colour(input logic [10:0] hh, input logic [10:0] vv);
    return {1'b1, hh[0] ^ vv[0], hh[1]};
  endfunction

  always @(posedge clk) begin
    rend_q1 <= colour(pixel_h, pixel_v);
    rend_q2 <= rend_q1;
  end
  assign pixel_in = rend_q2;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [4:0] stage0(input int st, input int pos);
    int  hh, vv;
    logic act, hs, vs;
    hh  = pos % HT;
    vv  = pos / HT;
    act = (st != ST_IDLE) && (hh < HV) && (vv < VV);
    hs  = (st != ST_IDLE) && (hh >= HV + HF) && (hh < HV + HF + HSW);
    vs  = (st != ST_IDLE) && (vv >= VV + VF) && (vv < VV + VF + VSW);
    return {act ? colour(11'(hh), 11'(vv)) : 3'b000, hs, vs};
  endfunction

  task automatic modelUpdate();
    logic last;
    if (rst) begin
      m_state = ST_IDLE;
      m_pos   = 0;
      m_fcnt  = '0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
      exp_out = '0;
    end else begin
      case (m_state)
        ST_IDLE: if (en) begin m_state = ST_RUN; m_pos = 0; end
        default: begin
          last  = (m_pos == FT - 1);
          m_pos = last ? 0 : m_pos + 1;
          if (last) m_fcnt = m_fcnt + 8'd1;
          if (m_state == ST_RUN) begin
            if (!en) m_state = ST_DRAIN;
          end else if (en) m_state = ST_RUN;
          else if (last) m_state = ST_IDLE;
        end
      endcase
      exp_out = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = stage0(m_state, m_pos);
    end
  endtask

  task automatic clockCycle();
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("pixel_h",     int'(pixel_h),     m_pos % HT);
    checkOutput("pixel_v",     int'(pixel_v),     m_pos / HT);
    checkOutput("frame_start", int'(frame_start), int'(m_state == ST_RUN && m_pos == 0));
    checkOutput("frame_cnt",   int'(frame_cnt),   int'(m_fcnt));
    checkOutput("vga_rgb",     int'(vga_rgb),     int'(exp_out[4:2]));
    checkOutput("vga_hs",      int'(vga_hs),      int'(exp_out[1]));
    checkOutput("vga_vs",      int'(vga_vs),      int'(exp_out[0]));
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) clockCycle();
  endtask

  task automatic waitForPos(input int p);
    int n;
    n = 0;
    do begin
      clockCycle();
      n++;
    end while (m_pos != p && n < 2 * FT);
    if (m_pos != p) checkOutput("wait_pos_timeout", m_pos, p);
  endtask

  initial begin
    int last_fs;
    int pulses;
    for (int i = 0; i < 3; i++) hist[i] = '0;

    // Reset values
    applyStimulus(3);
    checkOutput("rst_h", int'(pixel_h), 0);
    checkOutput("rst_hs", int'(vga_hs), 0);
    checkOutput("rst_fcnt", int'(frame_cnt), 0);
    rst = 1'b0;
    applyStimulus(2);

    // Start: frame_start on the very first RUN cycle
    en = 1'b1;
    clockCycle();
    checkOutput("first_fs", int'(frame_start), 1);
    checkOutput("first_h", int'(pixel_h), 0);
    applyStimulus(3 * FT);

    // Drop en mid-frame: scan drains to the frame end, then idles at (0,0)
    waitForPos(2 * HT);
    en = 1'b0;
    applyStimulus(FT - 2 * HT);
    checkOutput("drain_h", int'(pixel_h), 0);
    checkOutput("drain_v", int'(pixel_v), 0);
    checkOutput("drain_fcnt", int'(frame_cnt), 4);
    applyStimulus(6);
    checkOutput("idle_fs", int'(frame_start), 0);
    checkOutput("idle_hs", int'(vga_hs), 0);
    checkOutput("idle_rgb", int'(vga_rgb), 0);

    // Reassert en mid-drain: no stop, counter keeps going
    en = 1'b1;
    clockCycle();
    waitForPos(2 * HT);
    en = 1'b0;
    waitForPos(3 * HT);
    en = 1'b1;
    applyStimulus(FT);
    checkOutput("reassert_fcnt", int'(frame_cnt), 5);
    checkOutput("reassert_v", int'(pixel_v), 3);

    // Reset while hsync is active
    begin
      int n;
      n = 0;
      while (exp_out[1] !== 1'b1 && n < FT) begin
        clockCycle();
        n++;
      end
      checkOutput("hs_seen", int'(vga_hs), 1);
    end
    rst = 1'b1;
    clockCycle();
    checkOutput("midrst_hs", int'(vga_hs), 0);
    checkOutput("midrst_rgb", int'(vga_rgb), 0);
    checkOutput("midrst_fcnt", int'(frame_cnt), 0);
    checkOutput("midrst_h", int'(pixel_h), 0);
    rst = 1'b0;

    // 256 frames: frame_cnt wraps, frame_start every 98 clocks
    last_fs = -1;
    pulses  = 0;
    for (int c = 0; c <= 256 * FT; c++) begin
      clockCycle();
      if (frame_start) begin
        pulses++;
        if (last_fs >= 0) checkOutput("fs_period", c - last_fs, FT);
        last_fs = c;
      end
      if (c == 256 * FT - 1) checkOutput("fcnt_255", int'(frame_cnt), 255);
    end
    checkOutput("fcnt_wrap", int'(frame_cnt), 0);
    checkOutput("fs_pulses", pulses, 257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
